// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the write-arbiter request, issue, read-address and
// register-file write-port signals. The master side drives requests,
// the slave side (the arbiter) drives acceptance, hazard and write port.
interface regfile_write_arbiter_if;
  // Pipeline writeback request (always accepted)
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  // Long-latency unit write request with ready handshake
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;

  // Issue of a long-latency op (marks its destination busy)
  logic        iss_valid;
  logic [4:0]  iss_rd;

  // Register-file read addresses and resulting decode hazard
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic        stall;

  // Register-file write port and pending-write scoreboard
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] busy;

  modport master (
    output wb_valid, wb_addr, wb_data,
    output lu_valid, lu_addr, lu_data,
    output iss_valid, iss_rd,
    output A1, A2,
    input  lu_ready, stall, WE3, A3, WD3, busy
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  lu_valid, lu_addr, lu_data,
    input  iss_valid, iss_rd,
    input  A1, A2,
    output lu_ready, stall, WE3, A3, WD3, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single write port arbiter for a register file. Pipeline writebacks win
// every cycle; long-latency unit results wait in a small FIFO and drain
// whenever the pipeline leaves the port idle. A busy scoreboard tracks
// registers with an outstanding long-unit result and drives the decode
// stall together with the in-flight write on the port.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_FIFO = 2'd2
  } src_e;

  // Long-unit buffer
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  entry_t           head;
  logic             lu_ready_int;
  logic             push;
  logic             pop;

  // Arbitration and write port
  src_e             src;
  logic             we_q;
  logic [4:0]       a3_q;
  logic [31:0]      wd_q;

  // Scoreboard
  logic [31:0]      busy_q;
  logic [31:0]      busy_d;

  // A read port hazards when it names a non-zero register that is either
  // still awaiting its long-unit result or being written this very cycle.
  function automatic logic read_hazard(
    input logic [4:0]  a,
    input logic [31:0] busy_vec,
    input logic        we,
    input logic [4:0]  wa
  );
    return (a != 5'd0) && (busy_vec[a] || (we && (wa == a)));
  endfunction

  // Ready depends only on occupancy, never on a same-cycle pop, so the
  // long unit sees no combinational path from the writeback request.
  assign lu_ready_int = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push         = bus.lu_valid && lu_ready_int;
  assign head         = fifo_mem[rd_ptr];
  assign pop          = (src == SRC_FIFO);

  // Fixed-priority write-port source: writeback, then buffered long-unit entry
  always_comb begin
    // NOTE: assign a default before any branch so every path drives the
    // signal; a missing default in combinational logic infers a latch.
    src = SRC_NONE;
    if (bus.wb_valid) begin
      src = SRC_WB;
    end else if (fifo_count != '0) begin
      src = SRC_FIFO;
    end
  end

  // Buffer storage write on accepted long-unit request
  // NOTE: the storage array has no reset; validity is carried entirely by
  // the pointers and count, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: bus.lu_addr, data: bus.lu_data};
    end
  end

  // Buffer pointers and occupancy; pointers wrap naturally at a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered write port; register 0 is consumed but never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q <= 1'b0;
      a3_q <= '0;
      wd_q <= '0;
    end else begin
      case (src)
        SRC_WB: begin
          we_q <= (bus.wb_addr != 5'd0);
          a3_q <= bus.wb_addr;
          wd_q <= bus.wb_data;
        end
        SRC_FIFO: begin
          we_q <= (head.addr != 5'd0);
          a3_q <= head.addr;
          wd_q <= head.data;
        end
        default: begin
          we_q <= 1'b0;
        end
      endcase
    end
  end

  // Scoreboard next state: clear on drain, then set on issue so set wins
  always_comb begin
    busy_d = busy_q;
    if (pop && (head.addr != 5'd0)) begin
      busy_d[head.addr] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.lu_ready = lu_ready_int;
  assign bus.WE3      = we_q;
  assign bus.A3       = a3_q;
  assign bus.WD3      = wd_q;
  assign bus.busy     = busy_q;
  assign bus.stall    = read_hazard(bus.A1, busy_q, we_q, a3_q) ||
                        read_hazard(bus.A2, busy_q, we_q, a3_q);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: reset checks, a table of directed
// cycles, an asynchronous-reset sequence, and a randomized run compared
// against a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int NV    = 23;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending long-unit writes as a queue, scoreboard as a mask
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  logic act_ready;
  logic act_stall;

  // One directed cycle: inputs, pre-edge expectations, post-edge expectations
  typedef struct packed {
    logic        wb_v;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic        lu_v;
    logic [4:0]  lu_a;
    logic [31:0] lu_d;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        ready;
    logic        stall;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] busy;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [31:0] wv, input logic [31:0] wa, input logic [31:0] wd,
    input logic [31:0] lv, input logic [31:0] la, input logic [31:0] ld,
    input logic [31:0] iv, input logic [31:0] ir,
    input logic [31:0] a1, input logic [31:0] a2,
    input logic [31:0] rdy, input logic [31:0] stl,
    input logic [31:0] we, input logic [31:0] a3, input logic [31:0] wdat,
    input logic [31:0] bsy
  );
    vec_t v;
    v.wb_v = wv[0];  v.wb_a = wa[4:0]; v.wb_d = wd;
    v.lu_v = lv[0];  v.lu_a = la[4:0]; v.lu_d = ld;
    v.iss_v = iv[0]; v.iss_rd = ir[4:0];
    v.a1 = a1[4:0];  v.a2 = a2[4:0];
    v.ready = rdy[0]; v.stall = stl[0];
    v.we = we[0]; v.a3 = a3[4:0]; v.wd = wdat; v.busy = bsy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(
    input logic [31:0] wv, input logic [31:0] wa, input logic [31:0] wd,
    input logic [31:0] lv, input logic [31:0] la, input logic [31:0] ld,
    input logic [31:0] iv, input logic [31:0] ir,
    input logic [31:0] a1, input logic [31:0] a2
  );
    bus.wb_valid  = wv[0];
    bus.wb_addr   = wa[4:0];
    bus.wb_data   = wd;
    bus.lu_valid  = lv[0];
    bus.lu_addr   = la[4:0];
    bus.lu_data   = ld;
    bus.iss_valid = iv[0];
    bus.iss_rd    = ir[4:0];
    bus.A1        = a1[4:0];
    bus.A2        = a2[4:0];
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_a3   = '0;
    m_wd   = '0;
  endtask

  function automatic logic model_hazard(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return m_busy[a] || (m_we && (m_a3 == a));
  endfunction

  // Advance the model by one clock edge using the inputs present before it
  task automatic model_edge(
    input logic wv, input logic [4:0] wa, input logic [31:0] wd,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic iv, input logic [4:0] ir
  );
    ent_t e;
    logic accepted;
    accepted = lv && (m_q.size() < DEPTH);
    if (wv) begin
      m_we = (wa != 5'd0);
      m_a3 = wa;
      m_wd = wd;
    end else if (m_q.size() != 0) begin
      e    = m_q.pop_front();
      m_we = (e.addr != 5'd0);
      m_a3 = e.addr;
      m_wd = e.data;
      if (e.addr != 5'd0) m_busy[e.addr] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (iv && (ir != 5'd0)) m_busy[ir] = 1'b1;
    if (accepted) m_q.push_back({la, ld});
  endtask

  // One clock cycle with model comparison; called just after an active edge
  task automatic cycle();
    logic wv, lv, iv;
    logic [4:0] wa, la, ir;
    logic [31:0] wd, ld;
    #1;
    wv = bus.wb_valid;  wa = bus.wb_addr; wd = bus.wb_data;
    lv = bus.lu_valid;  la = bus.lu_addr; ld = bus.lu_data;
    iv = bus.iss_valid; ir = bus.iss_rd;
    act_ready = bus.lu_ready;
    act_stall = bus.stall;
    check("model_lu_ready", 32'(act_ready), 32'(m_q.size() < DEPTH));
    check("model_stall", 32'(act_stall),
          32'(model_hazard(bus.A1) || model_hazard(bus.A2)));
    @(posedge clk);
    model_edge(wv, wa, wd, lv, la, ld, iv, ir);
    #1;
    check("model_WE3", 32'(bus.WE3), 32'(m_we));
    check("model_A3", 32'(bus.A3), 32'(m_a3));
    check("model_WD3", bus.WD3, m_wd);
    check("model_busy", bus.busy, m_busy);
  endtask

  initial begin
    // Directed table: single wb write, scoreboard round trip, priority and
    // fill, register zero, set/clear collision, wb to a busy register.
    //            wb_v wb_a wb_d          lu_v lu_a lu_d   iv ir  a1 a2  rdy stl we a3 wd            busy
    vecs[0]  = mk(1, 5,  32'hDEADBEEF,   0, 0, 0,         0, 0, 0, 0,  1, 0, 1, 5,  32'hDEADBEEF, 0);
    vecs[1]  = mk(0, 0,  0,              0, 0, 0,         0, 0, 0, 0,  1, 0, 0, 5,  32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 0,  0,              0, 0, 0,         1, 7, 0, 0,  1, 0, 0, 5,  32'hDEADBEEF, 32'h80);
    vecs[3]  = mk(0, 0,  0,              1, 7, 32'h12,    0, 0, 7, 0,  1, 1, 0, 5,  32'hDEADBEEF, 32'h80);
    vecs[4]  = mk(0, 0,  0,              0, 0, 0,         0, 0, 7, 0,  1, 1, 1, 7,  32'h12,       0);
    vecs[5]  = mk(0, 0,  0,              0, 0, 0,         0, 0, 7, 0,  1, 1, 0, 7,  32'h12,       0);
    vecs[6]  = mk(0, 0,  0,              0, 0, 0,         0, 0, 7, 0,  1, 0, 0, 7,  32'h12,       0);
    vecs[7]  = mk(1, 10, 32'hA0,         1, 1, 32'h101,   0, 0, 0, 0,  1, 0, 1, 10, 32'hA0,       0);
    vecs[8]  = mk(1, 11, 32'hA1,         1, 2, 32'h102,   0, 0, 0, 0,  1, 0, 1, 11, 32'hA1,       0);
    vecs[9]  = mk(1, 12, 32'hA2,         1, 3, 32'h103,   0, 0, 0, 0,  0, 0, 1, 12, 32'hA2,       0);
    vecs[10] = mk(1, 13, 32'hA3,         1, 3, 32'h103,   0, 0, 0, 0,  0, 0, 1, 13, 32'hA3,       0);
    vecs[11] = mk(0, 0,  0,              1, 3, 32'h103,   0, 0, 0, 0,  0, 0, 1, 1,  32'h101,      0);
    vecs[12] = mk(0, 0,  0,              1, 3, 32'h103,   0, 0, 0, 0,  1, 0, 1, 2,  32'h102,      0);
    vecs[13] = mk(0, 0,  0,              0, 0, 0,         0, 0, 0, 0,  1, 0, 1, 3,  32'h103,      0);
    vecs[14] = mk(0, 0,  0,              0, 0, 0,         0, 0, 0, 0,  1, 0, 0, 3,  32'h103,      0);
    vecs[15] = mk(1, 0,  32'h55,         1, 0, 32'h66,    1, 0, 0, 0,  1, 0, 0, 0,  32'h55,       0);
    vecs[16] = mk(0, 0,  0,              0, 0, 0,         0, 0, 0, 0,  1, 0, 0, 0,  32'h66,       0);
    vecs[17] = mk(0, 0,  0,              0, 0, 0,         0, 0, 0, 0,  1, 0, 0, 0,  32'h66,       0);
    vecs[18] = mk(0, 0,  0,              1, 9, 32'h99,    1, 9, 0, 0,  1, 0, 0, 0,  32'h66,       32'h200);
    vecs[19] = mk(0, 0,  0,              0, 0, 0,         1, 9, 9, 0,  1, 1, 1, 9,  32'h99,       32'h200);
    vecs[20] = mk(0, 0,  0,              0, 0, 0,         0, 0, 9, 0,  1, 1, 0, 9,  32'h99,       32'h200);
    vecs[21] = mk(1, 9,  32'h77,         0, 0, 0,         0, 0, 0, 9,  1, 1, 1, 9,  32'h77,       32'h200);
    vecs[22] = mk(0, 0,  0,              0, 0, 0,         0, 0, 0, 9,  1, 1, 0, 9,  32'h77,       32'h200);

    // Reset held: outputs at reset values, no stall for non-zero read addresses
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 9);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_WE3", 32'(bus.WE3), 0);
    check("rst_A3", 32'(bus.A3), 0);
    check("rst_WD3", bus.WD3, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_lu_ready", 32'(bus.lu_ready), 1);
    check("rst_stall", 32'(bus.stall), 0);
    #2;
    reset = 1'b0;
    @(posedge clk);

    // Directed table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].wb_v, vecs[i].wb_a, vecs[i].wb_d,
            vecs[i].lu_v, vecs[i].lu_a, vecs[i].lu_d,
            vecs[i].iss_v, vecs[i].iss_rd, vecs[i].a1, vecs[i].a2);
      cycle();
      check($sformatf("v%0d_lu_ready", i), 32'(act_ready), 32'(vecs[i].ready));
      check($sformatf("v%0d_stall", i), 32'(act_stall), 32'(vecs[i].stall));
      check($sformatf("v%0d_WE3", i), 32'(bus.WE3), 32'(vecs[i].we));
      check($sformatf("v%0d_A3", i), 32'(bus.A3), 32'(vecs[i].a3));
      check($sformatf("v%0d_WD3", i), bus.WD3, vecs[i].wd);
      check($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
    end

    // Async reset between edges clears the scoreboard left by the table
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    #1;
    reset = 1'b0;
    model_reset();

    // Buffer two long-unit entries behind writebacks with r7 pending
    drive(1, 20, 32'h1, 1, 3, 32'h33, 1, 7, 7, 20);
    cycle();
    drive(1, 21, 32'h2, 1, 4, 32'h44, 0, 0, 7, 20);
    cycle();
    check("pre_rst_busy", bus.busy, 32'h80);
    check("pre_rst_lu_ready", 32'(bus.lu_ready), 0);
    check("pre_rst_stall", 32'(bus.stall), 1);

    // Reset pulse that never sees a clock edge
    #2;
    reset = 1'b1;
    #1;
    check("async_WE3", 32'(bus.WE3), 0);
    check("async_A3", 32'(bus.A3), 0);
    check("async_WD3", bus.WD3, 0);
    check("async_busy", bus.busy, 0);
    check("async_lu_ready", 32'(bus.lu_ready), 1);
    check("async_stall", 32'(bus.stall), 0);
    #1;
    reset = 1'b0;
    model_reset();

    // No discarded entry may reach the write port afterward
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 20);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("post_rst_WE3_%0d", i), 32'(bus.WE3), 0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      drive(32'($urandom_range(0, 99) < 45), $urandom_range(0, 7), $urandom,
            32'($urandom_range(0, 99) < 60), $urandom_range(0, 7), $urandom,
            32'($urandom_range(0, 99) < 30), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, long-unit write buffer depth, power of two, minimum 2.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 wb_valid  in  1  pipeline writeback request, always accepted, never back-pressured.
REQ-005 wb_addr  in  5  writeback destination register.
REQ-006 wb_data  in  32  writeback data.
REQ-007 lu_valid  in  1  long-latency unit write request.
REQ-008 lu_ready  out  1  long-unit request accepted this cycle when high with lu_valid.
REQ-009 lu_addr  in  5  long-unit destination register.
REQ-010 lu_data  in  32  long-unit data.
REQ-011 iss_valid  in  1  a long-latency op issues this cycle.
REQ-012 iss_rd  in  5  destination register of the issuing op.
REQ-013 A1, A2  in  5 each  current register-file read addresses.
REQ-014 stall  out  1  read hazard; decode must hold.
REQ-015 WE3  out  1  register-file write enable, registered.
REQ-016 A3  out  5  register-file write address, registered.
REQ-017 WD3  out  32  register-file write data, registered.
REQ-018 busy  out  32  scoreboard, bit r = register r has a pending long-unit write.

Function
REQ-019 lu_ready SHALL equal (fifo_count < FIFO_DEPTH); it SHALL NOT depend on a same-cycle pop.
REQ-020 lu_valid && lu_ready SHALL push {lu_addr, lu_data} into the FIFO at the next posedge.
REQ-021 Each posedge, the write-port source SHALL be selected by fixed priority: wb_valid first, else the FIFO head if the FIFO is non-empty, else none.
REQ-022 A selected FIFO head SHALL be popped in the same cycle; push and pop in one cycle SHALL leave fifo_count unchanged.
REQ-023 The selected request SHALL appear on WE3/A3/WD3 one cycle after selection; a wb request therefore has latency 1, and a long-unit request has minimum latency 2.
REQ-024 When no source is selected, WE3 SHALL be 0 and A3/WD3 SHALL hold their previous values.
REQ-025 A selected request with address 0 SHALL drive WE3=0 while still being consumed (FIFO popped).
REQ-026 iss_valid with iss_rd != 0 SHALL set busy[iss_rd] at the next posedge.
REQ-027 A popped FIFO entry with address r != 0 SHALL clear busy[r] at the same posedge that loads WE3.
REQ-028 A simultaneous set and clear of the same bit SHALL leave the bit set.
REQ-029 busy[0] SHALL be constantly 0.
REQ-030 stall SHALL be combinational and high when, for either read port p: A_p != 0 and (busy[A_p] or (WE3 and A3 == A_p)).
REQ-031 A wb request to a busy register SHALL be written normally and SHALL NOT alter busy.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated entries.

Reset
REQ-033 While reset is high: WE3=0, A3=0, WD3=0, FIFO empty, fifo_count=0, lu_ready=1, busy=0, and therefore stall=0 for any A1/A2.
REQ-034 Reset asserted mid-operation SHALL discard buffered FIFO entries and pending busy bits immediately, without waiting for clk.

Verification
REQ-035 Single wb write: wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF for one cycle -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; following cycle WE3=0.
REQ-036 Scoreboard round trip: iss_valid, iss_rd=7; then A1=7 -> busy[7]=1, stall=1. Then lu write addr=7 data=0x12 with wb idle -> WE3=1, A3=7, WD3=0x12 two cycles after acceptance, busy[7]=0; stall stays 1 that cycle (write-port match), then drops to 0.
REQ-037 Priority and fill: wb_valid held for 4 cycles while lu writes to 1, 2, 3 are offered -> lu_ready=0 after two accepts; A3 sequence shows only wb addresses; after wb drops, A3 shows 1 then 2, then lu 3 is accepted.
REQ-038 Register zero: wb_addr=0, plus iss_rd=0, plus an lu write to 0 -> WE3 never 1, busy=0, and the FIFO entry still drains (lu_ready returns to 1).
REQ-039 Async reset: reset pulse between clock edges with 2 FIFO entries buffered and busy=0x0000_0080 -> outputs reach reset values before the next edge; no buffered write appears afterward.
REQ-040 Set/clear collision: iss_rd=9 issued in the same cycle a FIFO entry for r9 pops -> WE3=1, A3=9, and busy[9] remains 1.
